if_id_stage: RTL and testbench
==============================

// Module: if_id_stage
// PURPOSE
//  Instruction-fetch stage with the IF/ID pipeline register for the 5-stage pipelined MIPS core.
//  - Holds the PC and drives the instruction-memory address.
//  - Captures each fetched word and its PC+4 into IF/ID.
//  - Presents decoded fields to ID, the hazard unit and forwarding. imm16 goes straight to signextend.
//  - Responds to stall from the hazard unit, flush/redirect from branch/jump resolution, and imem not-ready.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  BCNT_W     16             width of saturating fetch-bubble counter
// PORTS
//  clk              in   1   single clock; all state updates on posedge
//  reset            in   1   synchronous, active-high reset
//  stall_i          in   1   hazard unit: hold PC and IF/ID
//  flush_i          in   1   branch/jump taken: redirect PC, squash IF/ID
//  redirect_pc_i    in   32  target PC, used when flush_i=1
//  imem_ready_i     in   1   imem_rdata_i is valid this cycle
//  imem_rdata_i     in   32  instruction word at imem_addr_o (combinational read)
//  imem_addr_o      out  32  current PC
//  if_id_instr_o    out  32  registered instruction
//  if_id_pc4_o      out  32  registered PC+4 of that instruction
//  if_id_valid_o    out  1   IF/ID holds a real instruction
//  if_id_opcode_o   out  6   instr[31:26]
//  if_id_rs_o       out  5   instr[25:21]
//  if_id_rt_o       out  5   instr[20:16]
//  if_id_rd_o       out  5   instr[15:11]
//  if_id_imm16_o    out  16  instr[15:0], feeds signextend in_data
//  bubble_cnt_o     out  BCNT_W  fetch bubbles inserted since reset, saturating
// BEHAVIOUR
//  - Reset values: pc=RESET_PC, instr=32'h0 (NOP), pc4=0, valid=0, bubble_cnt=0.
//    reset overrides every other input in the same cycle.
//  - Per-edge priority: reset > flush > stall > !imem_ready > normal fetch.
//  - Normal (ready=1, no stall/flush): pc<=pc+4; instr<=imem_rdata_i; pc4<=pc+4; valid<=1.
//  - Stall without flush: pc, instr, pc4 and valid all hold. A stall never creates a bubble.
//  - Flush:
//    - pc<={redirect_pc_i[31:2],2'b00}, so misaligned low bits are forced to zero.
//    - instr<=0, pc4<=0, valid<=0.
//    - bubble_cnt increments.
//    - flush wins over simultaneous stall and over imem_ready_i=0.
//  - Not ready (no stall/flush): pc holds; instr<=0, pc4<=0, valid<=0; bubble_cnt increments.
//  - stall together with !ready: pure hold, no count.
//  - Latency: a word presented at imem_addr_o=P in cycle N appears on IF/ID outputs after edge N.
//  - PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0, with no flag.
//  - Field outputs are combinational slices of the registered instr. All are zero while valid=0.
//  - imem_addr_o is driven directly from the PC register, with no combinational path from inputs.
//  - bubble_cnt saturates at all-ones and never wraps.
// STRUCTURE
//  - Shared include mips_defs.vh holds:
//    - NOP_INSTR (32'h0) and PC_INC (4).
//    - Field bit ranges: OPC, RS, RT, RD, IMM.
//    - Common reset-PC default, also used by the decoder and hazard unit.
//  - One sub-module, pc_unit: PC register plus next-PC mux (pc+4 / redirect / hold).
//  - if_id_stage instantiates pc_unit and owns the IF/ID register and bubble counter.
// TESTING
//  1. Reset, imem_rdata=32'h8C22_0004, ready=1, one edge:
//     -> imem_addr=4, instr=8C220004, pc4=4, valid=1, rs=1, rt=2, imm16=0004.
//  2. From pc=8, stall_i=1 for 2 edges with changing rdata:
//     -> pc=8 and IF/ID unchanged, bubble_cnt unchanged.
//  3. stall_i=1, flush_i=1, redirect=32'h0000_0043:
//     -> pc=32'h40, instr=0, valid=0, bubble_cnt+1.
//  4. imem_ready=0 for 1 edge at pc=32'h40:
//     -> pc=32'h40, valid=0, bubble_cnt+1; ready=1 next edge -> pc=32'h44, valid=1.
//  5. flush to 32'hFFFF_FFFC, then one normal fetch:
//     -> pc=0, pc4=0, valid=1.
//  6. reset asserted together with flush and stall mid-run:
//     -> pc=RESET_PC, valid=0, bubble_cnt=0.
//     Force bubble_cnt near max -> holds at 16'hFFFF.

Source files
------------

// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the fetch stage: instruction field positions,
// PC constants, next-PC select encoding and the IF/ID payload.
package if_id_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INC           = 32'h0000_0004;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 26;
    localparam int unsigned RS_MSB  = 25;
    localparam int unsigned RS_LSB  = 21;
    localparam int unsigned RT_MSB  = 20;
    localparam int unsigned RT_LSB  = 16;
    localparam int unsigned RD_MSB  = 15;
    localparam int unsigned RD_LSB  = 11;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned IMM_LSB = 0;

    localparam int unsigned OPC_W = OPC_MSB - OPC_LSB + 1;
    localparam int unsigned REG_W = RS_MSB - RS_LSB + 1;
    localparam int unsigned IMM_W = IMM_MSB - IMM_LSB + 1;

    typedef enum logic [1:0] {
        PC_SEL_HOLD     = 2'd0,
        PC_SEL_INC      = 2'd1,
        PC_SEL_REDIRECT = 2'd2
    } pc_sel_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc4: '0, valid: 1'b0};

    // Instruction memory is word addressed; the two low PC bits are always zero.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_stage_pc_unit.sv
// Program counter register with its next-PC select (increment / redirect / hold).
module pc_unit
    import if_id_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            imem_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_c
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    pc_sel_e         sel;

    assign pc_plus4_c = pc_q + PC_INC;
    assign pc_o       = pc_q;

    // Flush beats stall and not-ready; only a clean ready cycle advances.
    always_comb begin
        sel = PC_SEL_HOLD;
        if (flush_i) begin
            sel = PC_SEL_REDIRECT;
        end else if (!stall_i && imem_ready_i) begin
            sel = PC_SEL_INC;
        end
    end

    always_comb begin
        pc_d = pc_q;
        unique case (sel)
            PC_SEL_INC:      pc_d = pc_plus4_c;
            PC_SEL_REDIRECT: pc_d = word_align(redirect_pc_i);
            default:         pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch stage: PC, IF/ID pipeline register, decoded field taps
// and a saturating count of fetch bubbles.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned     BCNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [XLEN-1:0]   redirect_pc_i,
    input  logic              imem_ready_i,
    input  logic [XLEN-1:0]   imem_rdata_i,
    output logic [XLEN-1:0]   imem_addr_o,
    output logic [XLEN-1:0]   if_id_instr_o,
    output logic [XLEN-1:0]   if_id_pc4_o,
    output logic              if_id_valid_o,
    output logic [OPC_W-1:0]  if_id_opcode_o,
    output logic [REG_W-1:0]  if_id_rs_o,
    output logic [REG_W-1:0]  if_id_rt_o,
    output logic [REG_W-1:0]  if_id_rd_o,
    output logic [IMM_W-1:0]  if_id_imm16_o,
    output logic [BCNT_W-1:0] bubble_cnt_o
);

    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
    if_id_t            if_id_q;
    logic [BCNT_W-1:0] bubble_cnt_q;
    logic              bubble;

    pc_unit #(
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_ready_i  (imem_ready_i),
        .pc_o          (pc),
        .pc_plus4_c    (pc_plus4)
    );

    // A bubble is a squash by flush, or an empty fetch that is not masked by a stall.
    assign bubble = flush_i || (!stall_i && !imem_ready_i);

    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_q <= IF_ID_BUBBLE;
        end else if (bubble) begin
            if_id_q <= IF_ID_BUBBLE;
        end else if (!stall_i) begin
            if_id_q <= '{instr: imem_rdata_i, pc4: pc_plus4, valid: 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= '0;
        end else if (bubble && (bubble_cnt_q != '1)) begin
            bubble_cnt_q <= bubble_cnt_q + BCNT_W'(1);
        end
    end

    assign imem_addr_o   = pc;
    assign if_id_instr_o = if_id_q.instr;
    assign if_id_pc4_o   = if_id_q.pc4;
    assign if_id_valid_o = if_id_q.valid;
    assign bubble_cnt_o  = bubble_cnt_q;

    // Field taps are forced to zero for an invalid slot so ID never sees stale registers.
    assign if_id_opcode_o = if_id_q.valid ? if_id_q.instr[OPC_MSB:OPC_LSB] : '0;
    assign if_id_rs_o     = if_id_q.valid ? if_id_q.instr[RS_MSB:RS_LSB]   : '0;
    assign if_id_rt_o     = if_id_q.valid ? if_id_q.instr[RT_MSB:RT_LSB]   : '0;
    assign if_id_rd_o     = if_id_q.valid ? if_id_q.instr[RD_MSB:RD_LSB]   : '0;
    assign if_id_imm16_o  = if_id_q.valid ? if_id_q.instr[IMM_MSB:IMM_LSB] : '0;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage; a second narrow-counter instance covers saturation.
module tb_if_id_stage;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] redirect_pc_i;
    logic        imem_ready_i;
    logic [31:0] imem_rdata_i;

    logic [31:0] imem_addr_o;
    logic [31:0] if_id_instr_o;
    logic [31:0] if_id_pc4_o;
    logic        if_id_valid_o;
    logic [5:0]  if_id_opcode_o;
    logic [4:0]  if_id_rs_o;
    logic [4:0]  if_id_rt_o;
    logic [4:0]  if_id_rd_o;
    logic [15:0] if_id_imm16_o;
    logic [15:0] bubble_cnt_o;

    logic [31:0] s_addr;
    logic [31:0] s_instr;
    logic [31:0] s_pc4;
    logic        s_valid;
    logic [5:0]  s_opcode;
    logic [4:0]  s_rs;
    logic [4:0]  s_rt;
    logic [4:0]  s_rd;
    logic [15:0] s_imm16;
    logic [3:0]  s_cnt;

    int checks;
    int errors;

    if_id_stage #(.RESET_PC(32'h0000_0000), .BCNT_W(16)) dut (
        .clk (clk), .reset (reset), .stall_i (stall_i), .flush_i (flush_i),
        .redirect_pc_i (redirect_pc_i), .imem_ready_i (imem_ready_i),
        .imem_rdata_i (imem_rdata_i), .imem_addr_o (imem_addr_o),
        .if_id_instr_o (if_id_instr_o), .if_id_pc4_o (if_id_pc4_o),
        .if_id_valid_o (if_id_valid_o), .if_id_opcode_o (if_id_opcode_o),
        .if_id_rs_o (if_id_rs_o), .if_id_rt_o (if_id_rt_o), .if_id_rd_o (if_id_rd_o),
        .if_id_imm16_o (if_id_imm16_o), .bubble_cnt_o (bubble_cnt_o)
    );

    if_id_stage #(.RESET_PC(32'h0000_0000), .BCNT_W(4)) dut_small (
        .clk (clk), .reset (reset), .stall_i (stall_i), .flush_i (flush_i),
        .redirect_pc_i (redirect_pc_i), .imem_ready_i (imem_ready_i),
        .imem_rdata_i (imem_rdata_i), .imem_addr_o (s_addr),
        .if_id_instr_o (s_instr), .if_id_pc4_o (s_pc4),
        .if_id_valid_o (s_valid), .if_id_opcode_o (s_opcode),
        .if_id_rs_o (s_rs), .if_id_rt_o (s_rt), .if_id_rd_o (s_rd),
        .if_id_imm16_o (s_imm16), .bubble_cnt_o (s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic fl, input logic [31:0] rpc,
                         input logic rdy, input logic [31:0] rdata);
        stall_i       = st;
        flush_i       = fl;
        redirect_pc_i = rpc;
        imem_ready_i  = rdy;
        imem_rdata_i  = rdata;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        tick();
        tick();
        checks++;
        if (imem_addr_o !== 32'h0 || if_id_instr_o !== 32'h0 || if_id_pc4_o !== 32'h0 ||
            if_id_valid_o !== 1'b0 || bubble_cnt_o !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: addr=%h instr=%h pc4=%h valid=%b cnt=%h, want 0/0/0/0/0",
                     imem_addr_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o, bubble_cnt_o);
        end
        checks++;
        if ({if_id_opcode_o, if_id_rs_o, if_id_rt_o, if_id_rd_o, if_id_imm16_o} !== 37'h0) begin
            errors++;
            $display("FAIL reset_fields: op=%h rs=%h rt=%h rd=%h imm=%h, want all 0",
                     if_id_opcode_o, if_id_rs_o, if_id_rt_o, if_id_rd_o, if_id_imm16_o);
        end
        reset = 1'b0;
    endtask

    task automatic test_first_fetch();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h8C22_0004);
        tick();
        checks++;
        if (imem_addr_o !== 32'h4 || if_id_instr_o !== 32'h8C22_0004 ||
            if_id_pc4_o !== 32'h4 || if_id_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL first_fetch: addr=%h instr=%h pc4=%h valid=%b, want 4/8c220004/4/1",
                     imem_addr_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o);
        end
        checks++;
        if (if_id_opcode_o !== 6'h23 || if_id_rs_o !== 5'd1 || if_id_rt_o !== 5'd2 ||
            if_id_rd_o !== 5'd0 || if_id_imm16_o !== 16'h0004) begin
            errors++;
            $display("FAIL first_fields: op=%h rs=%h rt=%h rd=%h imm=%h, want 23/1/2/0/0004",
                     if_id_opcode_o, if_id_rs_o, if_id_rt_o, if_id_rd_o, if_id_imm16_o);
        end
    endtask

    task automatic test_stall();
        // add $1,$2,$3 = 0x00430820
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0043_0820);
        tick();
        checks++;
        if (imem_addr_o !== 32'h8 || if_id_instr_o !== 32'h0043_0820 || if_id_pc4_o !== 32'h8 ||
            if_id_rd_o !== 5'd1 || if_id_rs_o !== 5'd2 || if_id_rt_o !== 5'd3) begin
            errors++;
            $display("FAIL second_fetch: addr=%h instr=%h pc4=%h rs=%h rt=%h rd=%h, want 8/00430820/8/2/3/1",
                     imem_addr_o, if_id_instr_o, if_id_pc4_o, if_id_rs_o, if_id_rt_o, if_id_rd_o);
        end
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h1111_1111);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h2222_2222);
        tick();
        checks++;
        if (imem_addr_o !== 32'h8 || if_id_instr_o !== 32'h0043_0820 || if_id_pc4_o !== 32'h8 ||
            if_id_valid_o !== 1'b1 || bubble_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL stall_hold: addr=%h instr=%h pc4=%h valid=%b cnt=%0d, want 8/00430820/8/1/0",
                     imem_addr_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o, bubble_cnt_o);
        end
    endtask

    task automatic test_flush_over_stall();
        drive(1'b1, 1'b1, 32'h0000_0043, 1'b1, 32'h3333_3333);
        tick();
        checks++;
        if (imem_addr_o !== 32'h40 || if_id_instr_o !== 32'h0 || if_id_pc4_o !== 32'h0 ||
            if_id_valid_o !== 1'b0 || bubble_cnt_o !== 16'd1) begin
            errors++;
            $display("FAIL flush_stall: addr=%h instr=%h pc4=%h valid=%b cnt=%0d, want 40/0/0/0/1",
                     imem_addr_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o, bubble_cnt_o);
        end
    endtask

    task automatic test_not_ready();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h4444_4444);
        tick();
        checks++;
        if (imem_addr_o !== 32'h40 || if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h0 ||
            bubble_cnt_o !== 16'd2) begin
            errors++;
            $display("FAIL not_ready: addr=%h valid=%b instr=%h cnt=%0d, want 40/0/0/2",
                     imem_addr_o, if_id_valid_o, if_id_instr_o, bubble_cnt_o);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h2001_FFFF);
        tick();
        checks++;
        if (imem_addr_o !== 32'h44 || if_id_valid_o !== 1'b1 || if_id_instr_o !== 32'h2001_FFFF ||
            if_id_pc4_o !== 32'h44 || if_id_imm16_o !== 16'hFFFF) begin
            errors++;
            $display("FAIL ready_resume: addr=%h valid=%b instr=%h pc4=%h imm=%h, want 44/1/2001ffff/44/ffff",
                     imem_addr_o, if_id_valid_o, if_id_instr_o, if_id_pc4_o, if_id_imm16_o);
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h5555_5555);
        tick();
        checks++;
        if (imem_addr_o !== 32'h44 || if_id_valid_o !== 1'b1 || if_id_instr_o !== 32'h2001_FFFF ||
            bubble_cnt_o !== 16'd2) begin
            errors++;
            $display("FAIL stall_not_ready: addr=%h valid=%b instr=%h cnt=%0d, want 44/1/2001ffff/2",
                     imem_addr_o, if_id_valid_o, if_id_instr_o, bubble_cnt_o);
        end
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h6666_6666);
        tick();
        checks++;
        if (imem_addr_o !== 32'hFFFF_FFFC || if_id_valid_o !== 1'b0 || bubble_cnt_o !== 16'd3) begin
            errors++;
            $display("FAIL flush_not_ready: addr=%h valid=%b cnt=%0d, want fffffffc/0/3",
                     imem_addr_o, if_id_valid_o, bubble_cnt_o);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0800_0010);
        tick();
        checks++;
        if (imem_addr_o !== 32'h0 || if_id_pc4_o !== 32'h0 || if_id_valid_o !== 1'b1 ||
            if_id_instr_o !== 32'h0800_0010 || if_id_opcode_o !== 6'h02) begin
            errors++;
            $display("FAIL pc_wrap: addr=%h pc4=%h valid=%b instr=%h op=%h, want 0/0/1/08000010/02",
                     imem_addr_o, if_id_pc4_o, if_id_valid_o, if_id_instr_o, if_id_opcode_o);
        end
    endtask

    task automatic test_reset_priority();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
        tick();
        reset = 1'b1;
        drive(1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h7777_7777);
        tick();
        checks++;
        if (imem_addr_o !== 32'h0 || if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h0 ||
            bubble_cnt_o !== 16'd0 || s_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_priority: addr=%h valid=%b instr=%h cnt=%0d small_cnt=%0d, want 0/0/0/0/0",
                     imem_addr_o, if_id_valid_o, if_id_instr_o, bubble_cnt_o, s_cnt);
        end
        reset = 1'b0;
    endtask

    task automatic test_saturation();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if (s_cnt !== 4'd14 || bubble_cnt_o !== 16'd14) begin
            errors++;
            $display("FAIL count_14: small=%0d main=%0d, want 14/14", s_cnt, bubble_cnt_o);
        end
        tick();
        checks++;
        if (s_cnt !== 4'hF) begin
            errors++;
            $display("FAIL count_max: small=%h, want f", s_cnt);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (s_cnt !== 4'hF || bubble_cnt_o !== 16'd20 || s_addr !== 32'h0) begin
            errors++;
            $display("FAIL saturate: small=%h main=%0d addr=%h, want f/20/0", s_cnt, bubble_cnt_o, s_addr);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        test_reset();
        test_first_fetch();
        test_stall();
        test_flush_over_stall();
        test_not_ready();
        test_wrap();
        test_reset_priority();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
